// File: rtl/ring_div_pkg.sv
// Shared types and constants for the ring-oscillator clock divider.
package ring_div_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      RUN    = 2'd2,
      DRAIN  = 2'd3
   } ring_state_e;

   localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/ring_div_phase.sv
// Phase counter for the divided clock: active/pending divisor, wrap and tick
// detection, and the registered clk_div/tick outputs.
module ring_div_phase
   import ring_div_pkg::*;
#(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             active,
   input  logic             start,
   input  logic             stop,
   input  logic             div_load,
   input  logic [DIV_W-1:0] div_i,
   output logic             wrap,
   output logic             clk_div_o,
   output logic             tick_o
);

   localparam logic [DIV_W-1:0] DMIN = DIV_W'(MIN_DIV);
   localparam logic [DIV_W-1:0] ONE  = DIV_W'(1);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] div_act;
   logic [DIV_W-1:0] div_pend;
   logic             pend_valid;

   logic [DIV_W-1:0] div_in;
   logic [DIV_W-1:0] div_next;
   logic [DIV_W-1:0] div_eff;
   logic [DIV_W-1:0] h_eff;
   logic [DIV_W-1:0] cnt_next;

   // A load on the wrap edge itself must govern the period starting there.
   always_comb begin
      div_in   = (div_i < DMIN) ? DMIN : div_i;
      wrap     = (cnt == div_act - ONE);
      div_next = div_load ? div_in : (pend_valid ? div_pend : div_act);
      div_eff  = wrap ? div_next : div_act;
      h_eff    = (div_eff >> 1) + {{(DIV_W-1){1'b0}}, div_eff[0]};
      cnt_next = wrap ? '0 : cnt + ONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         div_act    <= DMIN;
         div_pend   <= DMIN;
         pend_valid <= 1'b0;
         clk_div_o  <= 1'b0;
         tick_o     <= 1'b0;
      end else if (active) begin
         cnt <= cnt_next;
         if (wrap) begin
            div_act    <= div_next;
            pend_valid <= 1'b0;
         end else if (div_load) begin
            div_pend   <= div_in;
            pend_valid <= 1'b1;
         end
         clk_div_o <= !stop && (cnt_next < h_eff);
         tick_o    <= !stop && (cnt_next == div_eff - ONE);
      end else begin
         cnt        <= '0;
         pend_valid <= 1'b0;
         if (div_load) begin
            div_act  <= div_in;
            div_pend <= div_in;
         end
         clk_div_o <= start;
         tick_o    <= 1'b0;
      end
   end

endmodule

// File: rtl/ring_clk_divider.sv
// Programmable divider clocked by the ring oscillator: settle window, run,
// glitch-free drain, and a saturating completed-period count.
module ring_clk_divider
   import ring_div_pkg::*;
#(
   parameter int DIV_W         = 8,
   parameter int SETTLE_CYCLES = 4,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [DIV_W-1:0] div_i,
   input  logic             div_load,
   output logic             clk_div_o,
   output logic             tick_o,
   output logic             ready_o,
   output logic [CNT_W-1:0] periods_o,
   output ring_state_e      state_o
);

   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] PER_MAX     = '1;

   ring_state_e   state_q, state_d;
   logic [SW-1:0] settle_q, settle_d;
   logic          active, start, stop, clr_periods, wrap;

   assign active  = (state_q == RUN) || (state_q == DRAIN);
   assign state_o = state_q;

   // Valid/ready: en is a level request; ready_o high means clk_div_o is live.
   always_comb begin
      state_d     = state_q;
      settle_d    = settle_q;
      start       = 1'b0;
      stop        = 1'b0;
      clr_periods = 1'b0;
      case (state_q)
         IDLE: if (en) begin
            state_d     = SETTLE;
            settle_d    = '0;
            clr_periods = 1'b1;
         end
         SETTLE: begin
            if (!en) state_d = IDLE;
            else if (settle_q == SETTLE_LAST) begin
               state_d = RUN;
               start   = 1'b1;
            end else settle_d = settle_q + SW'(1);
         end
         // Dropping en exactly at a wrap means the current period is already done.
         RUN: if (!en) begin
            if (wrap) begin
               state_d = IDLE;
               stop    = 1'b1;
            end else state_d = DRAIN;
         end
         DRAIN: begin
            if (en) state_d = RUN;
            else if (wrap) begin
               state_d = IDLE;
               stop    = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         settle_q  <= '0;
         ready_o   <= 1'b0;
         periods_o <= '0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         ready_o  <= (state_d == RUN) || (state_d == DRAIN);
         if (clr_periods) periods_o <= '0;
         else if (active && wrap && periods_o != PER_MAX) periods_o <= periods_o + CNT_W'(1);
      end
   end

   ring_div_phase #(.DIV_W(DIV_W)) u_phase (
      .clk       (clk),
      .rst_n     (rst_n),
      .active    (active),
      .start     (start),
      .stop      (stop),
      .div_load  (div_load),
      .div_i     (div_i),
      .wrap      (wrap),
      .clk_div_o (clk_div_o),
      .tick_o    (tick_o)
   );

endmodule
